layer_header_fetch: RTL and testbench
=====================================

LAYER_HEADER_FETCH -- requirements
Module: layer_header_fetch

Interface
REQ-001 Parameter HEADER_BASE, default 26'd0: RAM word address of layer 0's header.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to fetch headers of layers 0..numLayers-1.
REQ-005 numLayers  input  8  number of layers to fetch; sampled only when start is accepted.
REQ-006 ramAddr  output  26  RAM word address of the current read request.
REQ-007 readRamEn  output  1  one-cycle RAM read strobe; ramAddr valid in the same cycle.
REQ-008 ramData  input  16  RAM read data.
REQ-009 ramDataValid  input  1  ramData valid for the outstanding request; arrives 1 or more cycles after readRamEn.
REQ-010 header  output  128  assembled 128-bit layer header for the ALU.
REQ-011 layerID  output  8  index of the layer whose header is presented.
REQ-012 headerValid  output  1  header and layerID valid.
REQ-013 headerReady  input  1  consumer accepts the header.
REQ-014 busy  output  1  high from start acceptance until done.
REQ-015 done  output  1  one-cycle pulse after the last header is accepted.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, PRESENT, FINISH.
- IDLE: start=1 and numLayers>0 -> ISSUE, layer=0, word=0.
- IDLE: start=1 and numLayers=0 -> FINISH.
- ISSUE: always -> WAIT.
- WAIT: ramDataValid=1 and word<7 -> ISSUE with word+1.
- WAIT: ramDataValid=1 and word=7 -> PRESENT.
- PRESENT: headerValid and headerReady, with layer<numLayers-1 -> ISSUE, layer+1, word=0.
- PRESENT: headerValid and headerReady, with layer=numLayers-1 -> FINISH.
- FINISH: always -> IDLE.
REQ-017 start SHALL be ignored in every state except IDLE; numLayers SHALL be latched on acceptance and later input changes ignored.
REQ-018 readRamEn SHALL be high exactly in ISSUE.
REQ-019 At most one RAM request SHALL be outstanding at any time.
REQ-020 ramAddr = (HEADER_BASE + layer*8 + word) mod 2^26, where layer*8 is {layer,3'b000} zero-extended.
REQ-021 Word 0 SHALL land in header[127:112] and word k in header[127-16k -: 16]; equivalently the shift-left, OR-in-low-word assembly the ALU header register uses.
REQ-022 ramDataValid outside WAIT SHALL be ignored, with no capture and no state change.
REQ-023 Latency: start accepted at edge k -> readRamEn=1 in cycle k+1.
REQ-024 Latency: ramDataValid at cycle d -> next readRamEn at cycle d+1; after the 8th word, headerValid=1 at cycle d+1.
REQ-025 headerValid SHALL be high exactly in PRESENT; header and layerID SHALL hold stable until accepted.
REQ-026 Next layer's first readRamEn SHALL occur in the cycle after the accepting handshake.
REQ-027 busy SHALL be high in ISSUE, WAIT, PRESENT and FINISH.
REQ-028 done SHALL be high exactly in FINISH.
REQ-029 headerReady outside PRESENT SHALL have no effect.
REQ-030 numLayers=255 SHALL fetch layers 0..254; the layer counter SHALL not wrap mid-sequence.

Reset
REQ-031 reset=1 SHALL force IDLE on the next edge regardless of state, including mid-fetch and mid-present.
REQ-032 Reset values: readRamEn=0, headerValid=0, busy=0, done=0, ramAddr=0, header=0, layerID=0, internal counters 0.
REQ-033 Any response returning after reset SHALL be discarded per REQ-022.
REQ-034 reset SHALL take priority over a simultaneous start.

Verification
REQ-035 HEADER_BASE=0, numLayers=1, RAM returns data 2 cycles after each request with word k = 16'h1000+k -> addresses 0..7 in order; header=128'h1000_1001_1002_1003_1004_1005_1006_1007; layerID=0; done pulses one cycle after acceptance.
REQ-036 numLayers=3, headerReady held low 5 cycles per header -> header stays stable while stalled; no readRamEn during PRESENT; layerIDs 0,1,2; layer 2 reads addresses 16..23.
REQ-037 numLayers=0 -> no readRamEn; busy high one cycle; done pulse one cycle after start.
REQ-038 HEADER_BASE=26'h3FFFFFC, layer 0 -> addresses 3FFFFFC..3FFFFFF, then 0..3 (wrap).
REQ-039 reset asserted in WAIT after 3 words, then stale ramDataValid -> IDLE, all outputs 0; stale data ignored; new start refetches from word 0.
REQ-040 start pulsed while busy, and spurious ramDataValid in IDLE -> no effect on sequence or outputs.

Source files
------------

// File: rtl/layer_header_fetch.sv
// ============================================================================
// Module      : layer_header_fetch
// Description : Fetches eight 16-bit RAM words per layer into a 128-bit
//               header and presents each header to the ALU with a handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_header_fetch #(
    parameter logic [25:0] HEADER_BASE = 26'd0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   numLayers,
    output logic [25:0]  ramAddr,
    output logic         readRamEn,
    input  logic [15:0]  ramData,
    input  logic         ramDataValid,
    output logic [127:0] header,
    output logic [7:0]   layerID,
    output logic         headerValid,
    input  logic         headerReady,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    localparam logic [2:0] C_LAST_WORD = 3'd7;

    state_t         state_q, state_d;
    logic [7:0]     layer_q, layer_d;
    logic [2:0]     word_q,  word_d;
    logic [7:0]     num_q,   num_d;
    logic [127:0]   header_q, header_d;
    logic [25:0]    w_addr;

    // Address arithmetic is 26 bits wide so the sum wraps naturally.
    assign w_addr = HEADER_BASE + {15'd0, layer_q, 3'b000} + {23'd0, word_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            layer_q  <= 8'd0;
            word_q   <= 3'd0;
            num_q    <= 8'd0;
            header_q <= 128'd0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            word_q   <= word_d;
            num_q    <= num_d;
            header_q <= header_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        word_d   = word_q;
        num_d    = num_q;
        header_d = header_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = numLayers;
                    layer_d = 8'd0;
                    word_d  = 3'd0;
                    state_d = (numLayers != 8'd0) ? S_ISSUE : S_FINISH;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (ramDataValid) begin
                    // Shift-left assembly leaves word 0 in the top 16 bits.
                    header_d = {header_q[111:0], ramData};
                    if (word_q == C_LAST_WORD) begin
                        state_d = S_PRESENT;
                    end else begin
                        word_d  = word_q + 3'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_PRESENT: begin
                if (headerReady) begin
                    if (layer_q == num_q - 8'd1) begin
                        state_d = S_FINISH;
                    end else begin
                        layer_d = layer_q + 8'd1;
                        word_d  = 3'd0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign readRamEn   = (state_q == S_ISSUE);
    assign ramAddr     = readRamEn ? w_addr : 26'd0;
    assign headerValid = (state_q == S_PRESENT);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign header      = header_q;
    assign layerID     = layer_q;

endmodule

`default_nettype wire

// File: tb/tb_layer_header_fetch.sv
// ============================================================================
// Module      : tb_layer_header_fetch
// Description : Table-driven bench for layer_header_fetch with a RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer_header_fetch;

    logic         clk = 1'b0;
    logic         reset, start, ramDataValid, headerReady;
    logic [7:0]   numLayers;
    logic [15:0]  ramData;

    logic [25:0]  a_ramAddr, b_ramAddr;
    logic         a_readRamEn, b_readRamEn;
    logic [127:0] a_header, b_header;
    logic [7:0]   a_layerID, b_layerID;
    logic         a_headerValid, b_headerValid;
    logic         a_busy, b_busy, a_done, b_done;

    always #5 clk = ~clk;

    layer_header_fetch #(.HEADER_BASE(26'd0)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .numLayers(numLayers),
        .ramAddr(a_ramAddr), .readRamEn(a_readRamEn), .ramData(ramData),
        .ramDataValid(ramDataValid), .header(a_header), .layerID(a_layerID),
        .headerValid(a_headerValid), .headerReady(headerReady),
        .busy(a_busy), .done(a_done)
    );

    // Second instance runs in lockstep to exercise address wrap-around.
    layer_header_fetch #(.HEADER_BASE(26'h3FFFFFC)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .numLayers(numLayers),
        .ramAddr(b_ramAddr), .readRamEn(b_readRamEn), .ramData(ramData),
        .ramDataValid(ramDataValid), .header(b_header), .layerID(b_layerID),
        .headerValid(b_headerValid), .headerReady(headerReady),
        .busy(b_busy), .done(b_done)
    );

    typedef struct {
        int           n;
        int           lat;
        int           stall;
        bit           poke;
        int           exp_reads;
        int           exp_hdrs;
        logic [127:0] exp_hdr0;
    } vec_t;

    int           total = 0;
    int           bad   = 0;
    bit           resp_en;
    int           lat, cd, ovl;
    logic [25:0]  pend;
    logic [25:0]  addrq[$];
    logic [25:0]  addrqb[$];
    logic [127:0] last_hdr;
    vec_t         vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_hdr(input int l);
        logic [127:0] h = '0;
        for (int k = 0; k < 8; k++) h = {h[111:0], 16'(16'h1000 + l * 8 + k)};
        return h;
    endfunction

    // Advance one cycle; the RAM model answers each request after lat cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        if (resp_en) begin
            ramDataValid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    ramDataValid = 1'b1;
                    ramData      = 16'h1000 + pend[15:0];
                end
            end
            if (a_readRamEn) begin
                if (cd > 0) ovl++;
                pend = a_ramAddr;
                cd   = lat;
                addrq.push_back(a_ramAddr);
                addrqb.push_back(b_ramAddr);
            end
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_readRamEn"}, a_readRamEn, 0);
        chk({tag, "_headerValid"}, a_headerValid, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_done"}, a_done, 0);
        chk({tag, "_ramAddr"}, a_ramAddr, 0);
        chk({tag, "_ramAddr_b"}, b_ramAddr, 0);
        chk({tag, "_header"}, a_header, 0);
        chk({tag, "_layerID"}, a_layerID, 0);
    endtask

    task automatic do_run(input vec_t r);
        int   hdrs = 0;
        int   stall_cnt = 0;
        int   addr_err = 0;
        bit   got_done = 0;
        bit   prev_acc = 0;
        bit   prev_valid = 0;
        addrq.delete();
        addrqb.delete();
        ovl = 0; lat = r.lat; cd = 0; resp_en = 1; headerReady = 0;
        start = 1; numLayers = r.n[7:0];
        tick();
        start = 0; numLayers = 8'd0;
        chk("busy_after_start", a_busy, 1);
        if (r.n > 0) chk("first_req", a_readRamEn, 1);
        else         chk("zero_done", a_done, 1);
        for (int c = 0; c < 6000 && !got_done; c++) begin
            if (prev_acc) begin
                if (hdrs < r.n) chk("next_layer_req", a_readRamEn, 1);
                else            chk("done_after_accept", a_done, 1);
            end
            if (prev_valid && !a_readRamEn) chk("last_word_to_valid", a_headerValid, 1);
            prev_valid  = ramDataValid;
            prev_acc    = 0;
            headerReady = 0;
            start       = 0;
            if (r.poke && c == 3) begin
                start = 1; numLayers = 8'd5;
            end
            if (a_done) begin
                got_done = 1;
            end else begin
                if (a_headerValid) begin
                    if (hdrs == 0) chk("hdr0_table", a_header, r.exp_hdr0);
                    chk("header", a_header, model_hdr(hdrs));
                    chk("layerID", a_layerID, hdrs);
                    chk("no_req_in_present", a_readRamEn, 0);
                    if (stall_cnt == r.stall) begin
                        headerReady = 1; prev_acc = 1; stall_cnt = 0; hdrs++;
                    end else begin
                        stall_cnt++;
                    end
                end
                tick();
            end
        end
        start = 0; numLayers = 8'd0; headerReady = 0;
        chk("done_seen", got_done, 1);
        chk("headers", hdrs, r.exp_hdrs);
        chk("reads", addrq.size(), r.exp_reads);
        for (int i = 0; i < addrq.size(); i++) begin
            if (addrq[i] !== 26'(i)) addr_err++;
            if (addrqb[i] !== 26'(26'h3FFFFFC + i)) addr_err++;
        end
        chk("addr_seq", addr_err, 0);
        chk("overlap", ovl, 0);
        tick();
        chk("busy_clear", a_busy, 0);
        chk("done_single", a_done, 0);
        if (r.n > 0) last_hdr = model_hdr(r.n - 1);
    endtask

    initial begin
        reset = 1; start = 0; numLayers = 0; ramData = 0; ramDataValid = 0;
        headerReady = 0; resp_en = 0; lat = 2; cd = 0; ovl = 0; last_hdr = '0;
        vecs[0] = '{1,   2, 0, 1'b0, 8,    1,   128'h1000_1001_1002_1003_1004_1005_1006_1007};
        vecs[1] = '{3,   2, 5, 1'b0, 24,   3,   128'h1000_1001_1002_1003_1004_1005_1006_1007};
        vecs[2] = '{2,   1, 0, 1'b1, 16,   2,   128'h1000_1001_1002_1003_1004_1005_1006_1007};
        vecs[3] = '{0,   2, 0, 1'b0, 0,    0,   128'h0};
        vecs[4] = '{255, 1, 0, 1'b0, 2040, 255, 128'h1000_1001_1002_1003_1004_1005_1006_1007};

        tick();
        tick();
        check_idle_zero("reset");
        reset = 0;
        tick();

        for (int v = 0; v < 5; v++) do_run(vecs[v]);

        // Spurious response data while idle must be ignored.
        resp_en = 0; ramDataValid = 1; ramData = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("spurious_busy", a_busy, 0);
            chk("spurious_req", a_readRamEn, 0);
            chk("spurious_header", a_header, last_hdr);
        end
        ramDataValid = 0; resp_en = 1;

        // Reset while waiting on the fourth word; its late response is stale.
        addrq.delete(); addrqb.delete(); lat = 3; cd = 0;
        start = 1; numLayers = 8'd1;
        tick();
        start = 0;
        for (int i = 0; i < 100 && addrq.size() < 4; i++) tick();
        chk("reach_word3", addrq.size(), 4);
        tick();
        chk("in_wait_busy", a_busy, 1);
        reset = 1;
        tick();
        reset = 0;
        check_idle_zero("midreset");
        tick();
        chk("stale_valid_seen", ramDataValid, 1);
        tick();
        chk("stale_busy", a_busy, 0);
        chk("stale_header", a_header, 0);
        chk("stale_req", a_readRamEn, 0);
        do_run(vecs[0]);

        // Reset wins over a simultaneous start.
        reset = 1; start = 1; numLayers = 8'd2;
        tick();
        reset = 0; start = 0; numLayers = 8'd0;
        chk("rst_prio_busy", a_busy, 0);
        tick();
        chk("rst_prio_busy2", a_busy, 0);
        chk("rst_prio_req", a_readRamEn, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
